// File: rtl/latent_dense_decoder.sv
// Dense decoder layer y[j] = act(sum_k z[k]*W[j][k] + b[j]) on one shared multiplier.
// Q(BITSIZE-FRAC-1).FRAC signed arithmetic with saturation and optional ReLU.
`default_nettype none

module latent_dense_decoder #(
  parameter int N_INPUT  = 2,
  parameter int M_OUTPUT = 4,
  parameter int BITSIZE  = 16,
  parameter int FRAC     = 11,
  parameter int RELU     = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_INPUT*BITSIZE-1:0]          z,
  input  logic [N_INPUT*M_OUTPUT*BITSIZE-1:0] weights,
  input  logic [M_OUTPUT*BITSIZE-1:0]         bias,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [M_OUTPUT*BITSIZE-1:0]     y,
  output logic                            busy
);

  localparam int KW = (N_INPUT > 1) ? $clog2(N_INPUT) : 1;
  localparam int JW = (M_OUTPUT > 1) ? $clog2(M_OUTPUT) : 1;
  localparam int PW = 2 * BITSIZE;
  localparam int AW = 2 * BITSIZE + $clog2(N_INPUT) + 2;
  localparam logic [KW-1:0] K_LAST = KW'(N_INPUT - 1);
  localparam logic [JW-1:0] J_LAST = JW'(M_OUTPUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    FIN  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t state, state_next;

  logic signed [BITSIZE-1:0] z_reg [N_INPUT];
  logic signed [BITSIZE-1:0] w_reg [M_OUTPUT][N_INPUT];
  logic signed [BITSIZE-1:0] b_reg [M_OUTPUT];
  logic signed [BITSIZE-1:0] y_reg [M_OUTPUT];
  logic [KW-1:0]             k;
  logic [JW-1:0]             j;
  logic signed [AW-1:0]      acc;

  logic signed [PW-1:0]      prod;
  logic signed [AW-1:0]      shifted;
  logic signed [BITSIZE-1:0] sat_val;
  logic signed [BITSIZE-1:0] result;
  logic                      overflow;

  always_comb begin
    prod     = z_reg[k] * w_reg[j][k];
    // Bias is aligned to the product scale (2*FRAC) before the single final shift.
    shifted  = (acc + (AW'(b_reg[j]) <<< FRAC)) >>> FRAC;
    overflow = !((&shifted[AW-1:BITSIZE-1]) || !(|shifted[AW-1:BITSIZE-1]));
    sat_val  = shifted[AW-1] ? {1'b1, {(BITSIZE-1){1'b0}}} : {1'b0, {(BITSIZE-1){1'b1}}};
    result   = overflow ? sat_val : shifted[BITSIZE-1:0];
    if ((RELU != 0) && result[BITSIZE-1]) begin
      result = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = MAC;
      MAC:     if (k == K_LAST) state_next = FIN;
      FIN:     state_next = (j == J_LAST) ? OUT : MAC;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k   <= '0;
      j   <= '0;
      acc <= '0;
      for (int kk = 0; kk < N_INPUT; kk++) z_reg[kk] <= '0;
      for (int jj = 0; jj < M_OUTPUT; jj++) begin
        b_reg[jj] <= '0;
        y_reg[jj] <= '0;
        for (int kk = 0; kk < N_INPUT; kk++) w_reg[jj][kk] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            k   <= '0;
            j   <= '0;
            acc <= '0;
            for (int kk = 0; kk < N_INPUT; kk++) z_reg[kk] <= z[kk*BITSIZE +: BITSIZE];
            for (int jj = 0; jj < M_OUTPUT; jj++) begin
              b_reg[jj] <= bias[jj*BITSIZE +: BITSIZE];
              for (int kk = 0; kk < N_INPUT; kk++) begin
                w_reg[jj][kk] <= weights[(jj*N_INPUT+kk)*BITSIZE +: BITSIZE];
              end
            end
          end
        end
        MAC: begin
          acc <= acc + AW'(prod);
          if (k != K_LAST) k <= k + 1'b1;
        end
        FIN: begin
          y_reg[j] <= result;
          acc      <= '0;
          k        <= '0;
          if (j != J_LAST) j <= j + 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < M_OUTPUT; g++) begin : g_y
    assign y[g*BITSIZE +: BITSIZE] = y_reg[g];
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_latent_dense_decoder.sv
// Directed bench for latent_dense_decoder; a ReLU and a linear instance run in lockstep.
`default_nettype none

module tb_latent_dense_decoder;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [31:0]  z;
  logic [127:0] weights;
  logic [63:0]  bias;

  logic         in_ready_r, out_valid_r, busy_r;
  logic         in_ready_l, out_valid_l, busy_l;
  logic [63:0]  y_r, y_l;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  latent_dense_decoder #(.RELU(1)) u_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r),
    .z(z), .weights(weights), .bias(bias), .out_valid(out_valid_r),
    .out_ready(out_ready), .y(y_r), .busy(busy_r)
  );

  latent_dense_decoder #(.RELU(0)) u_lin (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
    .z(z), .weights(weights), .bias(bias), .out_valid(out_valid_l),
    .out_ready(out_ready), .y(y_l), .busy(busy_l)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Handshake, then wait for out_valid; leaves the DUTs holding in OUT.
  task automatic launch(input string tag, input logic [31:0] zz, input logic [127:0] ww,
                        input logic [63:0] bb, input logic [63:0] exp_r, input logic [63:0] exp_l);
    int n;
    z        = zz;
    weights  = ww;
    bias     = bb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, " busy"}, 64'(busy_r), 64'd1);
    n = 0;
    while (out_valid_r !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'd12);
    chk({tag, " out_valid_lin"}, 64'(out_valid_l), 64'd1);
    chk({tag, " y_relu"}, y_r, exp_r);
    chk({tag, " y_lin"}, y_l, exp_l);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " out_valid_after"}, 64'(out_valid_r), 64'd0);
    chk({tag, " in_ready_after"}, 64'(in_ready_r), 64'd1);
  endtask

  localparam logic [31:0]  Z_BASIC = {16'h0400, 16'h0800};
  localparam logic [127:0] W_BASIC = {16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                      16'hF800, 16'h1000, 16'h0800, 16'h0800};
  localparam logic [63:0]  B_BASIC = {16'h0000, 16'h0000, 16'h0400, 16'h0000};
  // y0 = 1.0 + 0.5 = 1.5, y1 = 1.0*2.0 + 0.5*(-1.0) + 0.5 = 2.0
  localparam logic [63:0]  Y_BASIC = {16'h0000, 16'h0000, 16'h1000, 16'h0C00};

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    z         = '0;
    weights   = '0;
    bias      = '0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("reset out_valid", 64'(out_valid_r), 64'd0);
    chk("reset y_relu", y_r, 64'd0);
    chk("reset y_lin", y_l, 64'd0);
    chk("reset busy", 64'(busy_r), 64'd0);
    chk("reset in_ready", 64'(in_ready_r), 64'd1);
    tick();

    launch("basic", Z_BASIC, W_BASIC, B_BASIC, Y_BASIC, Y_BASIC);
    release_out("basic");
    chk("basic y_retained", y_r, Y_BASIC);

    // +-15.0 * 15.0 twice: both directions saturate.
    launch("sat", {16'h7800, 16'h7800},
           {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8800, 16'h8800, 16'h7800, 16'h7800},
           64'd0,
           {16'h0000, 16'h0000, 16'h0000, 16'h7FFF},
           {16'h0000, 16'h0000, 16'h8000, 16'h7FFF});
    release_out("sat");

    // y0 = 1.0 - 0.5, y1 = -2.0, y2 = 0.5 + 0.5 + 1.0
    launch("relu", {16'h0800, 16'h0800},
           {16'h0000, 16'h0000, 16'h0400, 16'h0400, 16'hF800, 16'hF800, 16'h0000, 16'h0800},
           {16'h0000, 16'h0800, 16'h0000, 16'hFC00},
           {16'h0000, 16'h1000, 16'h0000, 16'h0400},
           {16'h0000, 16'h1000, 16'hF000, 16'h0400});
    release_out("relu");

    // -1 LSB * 0.5 floors to -1 LSB; +1 LSB * 0.5 floors to 0.
    launch("trunc_neg", {16'h0000, 16'hFFFF}, {112'd0, 16'h0400}, 64'd0,
           64'd0, {16'h0000, 16'h0000, 16'h0000, 16'hFFFF});
    release_out("trunc_neg");
    launch("trunc_pos", {16'h0000, 16'h0001}, {112'd0, 16'h0400}, 64'd0, 64'd0, 64'd0);
    release_out("trunc_pos");

    launch("bp", Z_BASIC, W_BASIC, B_BASIC, Y_BASIC, Y_BASIC);
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      z        = $urandom;
      weights  = {$urandom, $urandom, $urandom, $urandom};
      tick();
      chk($sformatf("bp out_valid %0d", i), 64'(out_valid_r), 64'd1);
      chk($sformatf("bp in_ready %0d", i), 64'(in_ready_r), 64'd0);
      chk($sformatf("bp y %0d", i), y_r, Y_BASIC);
    end
    in_valid = 1'b0;
    release_out("bp");
    chk("bp busy_after", 64'(busy_r), 64'd0);
    chk("bp y_retained", y_r, Y_BASIC);

    // Hit a second transaction with reset five cycles in; y0 is already written.
    launch("pre", {16'h0000, 16'h0001}, {112'd0, 16'h0400}, 64'd0, 64'd0, 64'd0);
    release_out("pre");
    z        = Z_BASIC;
    weights  = W_BASIC;
    bias     = B_BASIC;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("midrst y0_before", y_r & 64'hFFFF, 64'h0C00);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst out_valid", 64'(out_valid_r), 64'd0);
    chk("midrst y_relu", y_r, 64'd0);
    chk("midrst y_lin", y_l, 64'd0);
    chk("midrst busy", 64'(busy_r), 64'd0);
    chk("midrst in_ready", 64'(in_ready_r), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    launch("again", Z_BASIC, W_BASIC, B_BASIC, Y_BASIC, Y_BASIC);
    release_out("again");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
